// File: rtl/csi_packet_sequencer_if.sv
// Header/payload handshake between the CSI-2 aligner/ECC stage and the packet sequencer,
// plus the line-buffer write port and status flags the sequencer drives.
interface csi_packet_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int LINE_W = 12
);
  logic              stop;
  logic              hdr_valid;
  logic [31:0]       hdr;
  logic              word_valid;
  logic [31:0]       word;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [LINE_W-1:0] line_cnt;
  logic              frame_active;
  logic              frame_start;
  logic              frame_end;
  logic              line_done;
  logic              err_trunc;
  logic              err_short;
  logic              busy;

  modport master (
    output stop, hdr_valid, hdr, word_valid, word,
    input  wr_en, wr_addr, wr_data, line_cnt, frame_active, frame_start,
           frame_end, line_done, err_trunc, err_short, busy
  );

  modport slave (
    input  stop, hdr_valid, hdr, word_valid, word,
    output wr_en, wr_addr, wr_data, line_cnt, frame_active, frame_start,
           frame_end, line_done, err_trunc, err_short, busy
  );
endinterface

// File: rtl/csi_packet_sequencer.sv
// CSI-2 packet sequencer: classifies ECC-clean headers and steps RAW8 payload into line-buffer writes.
// Optional macro CSI_VC_FILTER_EN: drop headers whose VC differs from VC_SEL.
module csi_packet_sequencer #(
  parameter int MAX_LINE_WORDS = 512,
  parameter int ADDR_W         = 9,
  parameter int LINE_W         = 12,
  parameter int VC_SEL         = 0
) (
  input logic                     mipi_clk,
  input logic                     reset_n,
  csi_packet_sequencer_if.slave   bus
);
  // state   | meaning
  // IDLE    | waiting for a packet header
  // PAYLOAD | storing RAW8 payload words into the line buffer
  // SKIP    | discarding CRC/trailer or an unwanted packet until stop
  typedef enum logic [1:0] {IDLE, PAYLOAD, SKIP} state_t;

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_LINE_WORDS);

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_LS   = 6'h02;
  localparam logic [5:0] DT_LE   = 6'h03;
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  state_t            state;
  logic [14:0]       remaining;
  logic [IDX_W-1:0]  idx;
  logic              wr_en, frame_active, frame_start, frame_end, line_done;
  logic              err_trunc, err_short, busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [LINE_W-1:0] line_cnt;

  logic [5:0]  dt;
  logic [15:0] wc;
  logic [16:0] wc_plus3;
  logic [14:0] words_init;
  logic        vc_ok;
  logic        unused_hdr;

  assign dt         = bus.hdr[5:0];
  assign wc         = bus.hdr[23:8];
  assign wc_plus3   = {1'b0, wc} + 17'd3;
  assign words_init = 15'(wc_plus3 >> 2);

`ifdef CSI_VC_FILTER_EN
  assign vc_ok      = (bus.hdr[7:6] == 2'(VC_SEL));
  assign unused_hdr = ^bus.hdr[31:24];
`else
  assign vc_ok      = 1'b1;
  assign unused_hdr = ^{bus.hdr[31:24], bus.hdr[7:6]};
`endif

  always_ff @(posedge mipi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      remaining    <= '0;
      idx          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      line_cnt     <= '0;
      frame_active <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      line_done    <= 1'b0;
      err_trunc    <= 1'b0;
      err_short    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hdr_valid && !vc_ok) begin
            state <= SKIP;
          end else if (bus.hdr_valid) begin
            case (dt)
              DT_FS: begin
                frame_start  <= 1'b1;
                frame_active <= 1'b1;
                line_cnt     <= '0;
                err_trunc    <= 1'b0;
                err_short    <= 1'b0;
              end
              DT_FE: begin
                frame_end    <= 1'b1;
                frame_active <= 1'b0;
              end
              DT_LS, DT_LE: ;
              DT_RAW8: begin
                if (frame_active && wc != 16'd0) begin
                  remaining <= words_init;
                  idx       <= '0;
                  wr_addr   <= '0;
                  busy      <= 1'b1;
                  state     <= PAYLOAD;
                end else begin
                  state <= SKIP;
                end
              end
              default: state <= SKIP;
            endcase
          end
        end
        PAYLOAD: begin
          // stop wins over a coincident word: the burst is already gone
          if (bus.stop) begin
            err_short <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (bus.word_valid) begin
            if (idx < IDX_MAX) begin
              wr_en   <= 1'b1;
              wr_data <= bus.word;
              wr_addr <= idx[ADDR_W-1:0];
            end else begin
              err_trunc <= 1'b1;
            end
            if (idx != IDX_MAX) idx <= idx + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == 15'd1) begin
              line_done <= 1'b1;
              line_cnt  <= line_cnt + 1'b1;
              busy      <= 1'b0;
              state     <= SKIP;
            end
          end
        end
        SKIP: begin
          if (bus.stop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en        = wr_en;
  assign bus.wr_addr      = wr_addr;
  assign bus.wr_data      = wr_data;
  assign bus.line_cnt     = line_cnt;
  assign bus.frame_active = frame_active;
  assign bus.frame_start  = frame_start;
  assign bus.frame_end    = frame_end;
  assign bus.line_done    = line_done;
  assign bus.err_trunc    = err_trunc;
  assign bus.err_short    = err_short;
  assign bus.busy         = busy;
endmodule

// File: doc/csi_packet_sequencer.md
Name: csi_packet_sequencer

Overview:
- Sequences CSI-2 packet reception after the lane/byte-alignment and header-ECC stages, in the `mipi_clk` domain.
- Classifies each ECC-clean packet header as:
  - short packet: frame start (FS), frame end (FE), line start (LS), line end (LE);
  - long packet: RAW8 (0x2A) or other.
- Steps through the RAW8 payload words and generates line-buffer write strobes, addresses, line/frame counters and error flags.
- Feeds the pixel/line-buffer stage that drives `red`/`green`/`blue`/`adress_out`.

Parameters:
- MAX_LINE_WORDS, 512, maximum 32-bit payload words stored per line; also sizes `wr_addr`.
- ADDR_W, 9, width of `wr_addr`; must satisfy 2^ADDR_W >= MAX_LINE_WORDS.
- LINE_W, 12, width of `line_cnt`.
- VC_SEL, 0, virtual channel accepted when CSI_VC_FILTER_EN is defined.

Ports:
- mipi_clk  in  1  byte/word clock of the receive datapath
- reset_n  in  1  asynchronous, active-low reset
- stop  in  1  HS burst ended / receiver stopped (level, synchronous to `mipi_clk`)
- hdr_valid  in  1  one-cycle pulse: `hdr` holds an ECC-clean header
- hdr  in  32  `[5:0]` DT, `[7:6]` VC, `[23:8]` WC, `[31:24]` ECC
- word_valid  in  1  `word` holds the next aligned 32-bit payload word
- word  in  32  payload word, byte0 in `[7:0]`
- wr_en  out  1  line-buffer write strobe
- wr_addr  out  ADDR_W  word address within the line
- wr_data  out  32  registered copy of `word`
- line_cnt  out  LINE_W  index of the current line within the frame
- frame_active  out  1  high between FS and FE
- frame_start  out  1  one-cycle pulse on FS
- frame_end  out  1  one-cycle pulse on FE
- line_done  out  1  one-cycle pulse when a RAW8 line completes
- err_trunc  out  1  sticky: WC exceeded capacity; cleared on FS
- err_short  out  1  sticky: `stop` arrived mid-payload; cleared on FS
- busy  out  1  high in PAYLOAD

Behaviour:
- Reset values: all outputs 0; state IDLE; internal remaining-word counter 0.
- Every output is registered.
- States and transitions:
  - IDLE, on `hdr_valid`, by DT:
    - 0x00 (FS): `frame_start`=1; `frame_active`<=1; `line_cnt`<=0; clear `err_*`.
    - 0x01 (FE): `frame_end`=1; `frame_active`<=0.
    - 0x02 (LS), 0x03 (LE): ignored, stay in IDLE.
    - 0x2A (RAW8) with `frame_active`=1 and WC != 0: latch remaining = ceil(WC/4) = `(WC+3)>>2`, computed 17-bit; `wr_addr`<=0; go to PAYLOAD.
    - 0x2A with WC = 0, any other DT, or RAW8 while `frame_active`=0: go to SKIP.
  - PAYLOAD, on each `word_valid`:
    - if `wr_addr` < MAX_LINE_WORDS: `wr_en`=1, `wr_data`<=`word`.
    - else: `wr_en`=0 and set `err_trunc`.
    - then remaining-1 and `wr_addr`+1, saturating at MAX_LINE_WORDS.
    - On the last word (remaining==1): pulse `line_done`; `line_cnt`+1, wrapping modulo 2^LINE_W; go to SKIP, which discards the CRC/trailer.
  - SKIP: ignore `word_valid` and `hdr_valid`; go to IDLE when `stop`=1.
- Latency: `wr_en`/`wr_data`/`wr_addr` follow the accepted `word_valid` by exactly 1 cycle. Header pulses (`frame_start`, `frame_end`) follow `hdr_valid` by 1 cycle.
- `stop` in PAYLOAD: set `err_short`; no `line_done`; `line_cnt` unchanged; go to IDLE in the same cycle. `stop` has priority over a simultaneous `word_valid`.
- `stop` in IDLE: no effect.
- `hdr_valid` in PAYLOAD: ignored, because a header cannot appear inside a burst.
- `frame_start`, `frame_end` and `line_done` are never asserted together.
- Second FS while `frame_active`: treated as a new frame; `line_cnt`<=0.
- Asynchronous `reset_n` mid-packet: all state cleared immediately; no partial write is completed.

Optional Feature:
- Macro CSI_VC_FILTER_EN.
- Defined: any header with VC != VC_SEL is treated as an unknown DT (goes to SKIP, no pulses, no counter change).
- Undefined: VC bits are ignored; all channels are processed.

Test Plan:
- Reset release; FS header (DT 0x00) -> `frame_start` one pulse, `frame_active`=1, `line_cnt`=0, `err_*`=0.
- RAW8 header WC=16, then 4 words 0x03020100..0x0F0E0D0C, then `stop` -> `wr_en` for 4 cycles at `wr_addr` 0..3 with matching data, `line_done` once, `line_cnt`=1.
- RAW8 WC=6 -> exactly 2 writes (ceil(6/4)); a 3rd `word_valid` before `stop` produces no write.
- MAX_LINE_WORDS=4, WC=24 -> 4 writes, `err_trunc`=1, `line_done` after the 6th word, `line_cnt`+1.
- RAW8 WC=16 with `stop` after 2 words -> `err_short`=1, no `line_done`, `line_cnt` unchanged; the next FS clears `err_short`.
- CSI_VC_FILTER_EN defined, VC_SEL=0: RAW8 header with VC=1 -> no writes, no `line_done`; FE on VC=0 -> `frame_end` pulse, `frame_active`=0.
